// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous input.
// The reset value is a parameter so idle-high inputs can reset high.
module spi_sync #(
    parameter int N       = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetq,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            ff <= {N{RST_VAL}};
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with 8-bit rx register and one-deep tx holding register.
// All SPI pins are oversampled by clk; sck must run at clk/8 or slower.
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       tx_full,
    output logic       overrun,
    output logic       selected
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEL  = 1'b1;

    logic       state;
    logic       state_nx;
    logic       sck_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sck_q;
    logic       cs_q;
    logic [2:0] cnt;
    logic [7:0] rx_sh;
    logic [7:0] tx_sh;
    logic [7:0] hold;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .resetq(resetq), .d(sck), .q(sck_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .resetq(resetq), .d(cs_n), .q(cs_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetq(resetq), .d(mosi), .q(mosi_s)
    );

    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;
    logic enter;
    logic in_sel;
    logic load;
    logic done;
    logic [7:0] rx_byte;

    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign cs_rise  = cs_s & ~cs_q;
    assign in_sel   = (state == ST_SEL);
    assign enter    = (state == ST_IDLE) & cs_fall;
    // Byte boundary fall reloads instead of shifting.
    assign load     = enter | (in_sel & sck_fall & (cnt == 3'd0));
    assign done     = in_sel & sck_rise & (cnt == 3'd7);
    assign rx_byte  = {rx_sh[6:0], mosi_s};

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (cs_fall) state_nx = ST_SEL;
            ST_SEL:  if (cs_rise) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        selected = (state == ST_SEL);
        miso_oe  = selected;
        miso     = tx_sh[7];
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            cnt     <= 3'd0;
            rx_sh   <= 8'h00;
            tx_sh   <= 8'h00;
            hold    <= 8'h00;
            rx_data <= 8'h00;
            valid   <= 1'b0;
            tx_full <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sck_q <= sck_s;
            cs_q  <= cs_s;
            if (enter) begin
                cnt <= 3'd0;
            end else if (in_sel & sck_rise) begin
                cnt   <= cnt + 3'd1;
                rx_sh <= rx_byte;
            end
            if (load) begin
                tx_sh <= tx_full ? hold : IDLE_BYTE;
            end else if (in_sel & sck_fall) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            // A write racing a load refills the holding register.
            if (wr) begin
                hold    <= tx_data;
                tx_full <= 1'b1;
            end else if (load) begin
                tx_full <= 1'b0;
            end
            if (done) begin
                rx_data <= rx_byte;
            end
            valid <= done | (valid & ~rd);
            if (rd) begin
                overrun <= 1'b0;
            end else if (done & valid) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: vector table, corner sequences,
// and randomized transactions against a byte-level reference model.
module tb_spi_target;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       valid;
    logic       tx_full;
    logic       overrun;
    logic       selected;

    int tests = 0;
    int fails = 0;

    spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .resetq(resetq), .sck(sck), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .rd(rd),
        .wr(wr), .tx_data(tx_data), .rx_data(rx_data),
        .valid(valid), .tx_full(tx_full), .overrun(overrun),
        .selected(selected)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr_en;
        logic [7:0] wr_data;
        logic [7:0] host;
        bit         rd_after;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        bit         exp_valid;
        bit         exp_over;
    } vec_t;

    vec_t vt[5];

    // Byte-level reference model state.
    bit         m_full;
    logic [7:0] m_hold;
    bit         m_valid;
    bit         m_over;
    logic [7:0] m_rx;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr_pulse(input logic [7:0] d);
        tx_data = d;
        wr = 1'b1;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic rd_pulse();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(1);
    endtask

    task automatic sel_begin();
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic sel_end();
        tick(2);
        cs_n = 1'b1;
        tick(6);
    endtask

    // Mode 0: host samples miso and presents mosi while sck is low.
    task automatic send_bits(input logic [7:0] b, input int nbits,
                             input bit rd_done, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            tick(4);
            got[i] = miso;
            sck = 1'b1;
            if (rd_done && i == 0) begin
                tick(SYNC);
                rd = 1'b1;
                tick(1);
                rd = 1'b0;
                tick(4 - SYNC - 1);
            end else begin
                tick(4);
            end
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input bit rd_done,
                        output logic [7:0] got);
        sel_begin();
        send_bits(b, 8, rd_done, got);
        sel_end();
    endtask

    task automatic do_reset();
        resetq = 1'b0;
        tick(3);
        resetq = 1'b1;
        tick(3);
    endtask

    logic [7:0] got;
    logic [7:0] got2;

    initial begin
        vt[0] = '{1'b0, 8'h00, 8'hA5, 1'b0, 8'hFF, 8'hA5, 1'b1, 1'b0};
        vt[1] = '{1'b1, 8'h3C, 8'h00, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1};
        vt[2] = '{1'b0, 8'h00, 8'h11, 1'b0, 8'hFF, 8'h11, 1'b1, 1'b0};
        vt[3] = '{1'b0, 8'h00, 8'h22, 1'b1, 8'hFF, 8'h22, 1'b1, 1'b1};
        vt[4] = '{1'b1, 8'h5A, 8'h7E, 1'b1, 8'h5A, 8'h7E, 1'b1, 1'b0};

        tick(3);
        check("rst_selected", selected, 0);
        check("rst_valid", valid, 0);
        check("rst_rx", rx_data, 8'h00);
        check("rst_miso_oe", miso_oe, 0);
        resetq = 1'b1;
        tick(3);

        for (int k = 0; k < 5; k++) begin
            if (vt[k].wr_en) begin
                wr_pulse(vt[k].wr_data);
                check($sformatf("v%0d_full_wr", k), tx_full, 1);
            end
            sel_begin();
            check($sformatf("v%0d_full_sel", k), tx_full, 0);
            check($sformatf("v%0d_oe", k), miso_oe, 1);
            send_bits(vt[k].host, 8, 1'b0, got);
            sel_end();
            check($sformatf("v%0d_miso", k), got, vt[k].exp_miso);
            check($sformatf("v%0d_rx", k), rx_data, vt[k].exp_rx);
            check($sformatf("v%0d_valid", k), valid, vt[k].exp_valid);
            check($sformatf("v%0d_over", k), overrun, vt[k].exp_over);
            if (vt[k].rd_after) begin
                rd_pulse();
                check($sformatf("v%0d_valid_rd", k), valid, 0);
                check($sformatf("v%0d_over_rd", k), overrun, 0);
            end
        end

        // rd coincident with byte completion
        xfer(8'h12, 1'b0, got);
        xfer(8'h55, 1'b1, got);
        check("rdsame_rx", rx_data, 8'h55);
        check("rdsame_valid", valid, 1);
        check("rdsame_over", overrun, 0);
        rd_pulse();

        // last write wins
        wr_pulse(8'h01);
        wr_pulse(8'h99);
        check("lww_full", tx_full, 1);
        xfer(8'h00, 1'b0, got);
        check("lww_miso", got, 8'h99);
        check("lww_full_after", tx_full, 0);
        rd_pulse();

        // wr in the same cycle as the select load, then two bytes
        wr_pulse(8'h44);
        cs_n = 1'b0;
        tick(SYNC);
        tx_data = 8'h66;
        wr = 1'b1;
        tick(1);
        wr = 1'b0;
        tick(3);
        check("race_full", tx_full, 1);
        send_bits(8'h0F, 8, 1'b0, got);
        send_bits(8'hF0, 8, 1'b0, got2);
        sel_end();
        check("race_b0", got, 8'h44);
        check("race_b1", got2, 8'h66);
        check("race_full_end", tx_full, 0);
        check("race_rx", rx_data, 8'hF0);
        check("race_over", overrun, 1);
        rd_pulse();

        // aborted partial byte
        sel_begin();
        send_bits(8'hE7, 5, 1'b0, got);
        sel_end();
        check("abort_valid", valid, 0);
        check("abort_rx", rx_data, 8'hF0);
        check("abort_sel", selected, 0);
        xfer(8'hC3, 1'b0, got);
        check("abort_next_rx", rx_data, 8'hC3);
        check("abort_next_valid", valid, 1);
        check("abort_next_over", overrun, 0);

        // reset mid-transfer
        sel_begin();
        wr_pulse(8'h77);
        send_bits(8'hBD, 4, 1'b0, got);
        #1 resetq = 1'b0;
        #1;
        check("mrst_miso", miso, 0);
        check("mrst_oe", miso_oe, 0);
        check("mrst_rx", rx_data, 8'h00);
        check("mrst_valid", valid, 0);
        check("mrst_full", tx_full, 0);
        check("mrst_over", overrun, 0);
        check("mrst_sel", selected, 0);
        tick(1);
        cs_n = 1'b1;
        sck = 1'b0;
        tick(2);
        resetq = 1'b1;
        tick(6);
        check("mrst_wait", selected, 0);
        xfer(8'h81, 1'b0, got);
        check("mrst_rx81", rx_data, 8'h81);
        check("mrst_valid81", valid, 1);
        check("mrst_miso81", got, 8'hFF);

        // randomized transactions against the byte-level model
        do_reset();
        m_full = 0; m_hold = 8'h00; m_valid = 0; m_over = 0; m_rx = 8'h00;
        for (int n = 0; n < 30; n++) begin
            bit         dw;
            bit         dr;
            logic [7:0] d;
            logic [7:0] b;
            logic [7:0] em;
            dw = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            b  = 8'($urandom);
            if (dw) begin
                wr_pulse(d);
                m_hold = d;
                m_full = 1;
            end
            em = m_full ? m_hold : 8'hFF;
            m_full = 0;
            xfer(b, 1'b0, got);
            if (m_valid) m_over = 1;
            m_valid = 1;
            m_rx = b;
            check($sformatf("r%0d_miso", n), got, em);
            check($sformatf("r%0d_rx", n), rx_data, m_rx);
            check($sformatf("r%0d_valid", n), valid, m_valid);
            check($sformatf("r%0d_over", n), overrun, m_over);
            check($sformatf("r%0d_full", n), tx_full, m_full);
            if (dr) begin
                rd_pulse();
                m_valid = 0;
                m_over = 0;
                check($sformatf("r%0d_valid_rd", n), valid, m_valid);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sck, mosi and cs_n (minimum 2).
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF: byte shifted out when no transmit data is pending.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 resetq  input  1  reset, asynchronous, active-low.
REQ-005 sck  input  1  external SPI clock; mode 0 only (CPOL=0, CPHA=0).
REQ-006 cs_n  input  1  external chip select, active-low.
REQ-007 mosi  input  1  serial data from the host, MSB first.
REQ-008 miso  output  1  serial data to the host, MSB first.
REQ-009 miso_oe  output  1  miso drive enable; 1 only while the block is selected.
REQ-010 rd  input  1  one-cycle pulse: consume rx_data and clear valid and overrun.
REQ-011 wr  input  1  one-cycle pulse: load tx_data into the transmit holding register.
REQ-012 tx_data  input  8  byte to be sent to the host.
REQ-013 rx_data  output  8  last complete byte received.
REQ-014 valid  output  1  rx_data holds an unconsumed byte.
REQ-015 tx_full  output  1  the holding register has not yet been transferred to the shifter.
REQ-016 overrun  output  1  sticky flag: a byte completed while valid=1.
REQ-017 selected  output  1  synchronized, inverted cs_n (the SEL state).

Function
REQ-018 sck, cs_n and mosi SHALL each pass through SYNC_STAGES flops; edges are detected on the synchronized values only.
REQ-019 SCK frequency SHALL be at most clk/8; correct behaviour above that rate is not required.
REQ-020 State machine SHALL have two states: IDLE (cs_n high) and SEL. IDLE->SEL on a synchronized cs_n fall; SEL->IDLE on a synchronized cs_n rise.
REQ-021 On IDLE->SEL, the bit counter SHALL clear to 0.
REQ-022 On IDLE->SEL, the tx shifter SHALL load the holding register if tx_full=1, else IDLE_BYTE; tx_full SHALL then clear.
REQ-023 In SEL, on each synchronized sck rise, mosi SHALL shift into the rx shifter LSB and the 3-bit bit counter SHALL increment, wrapping 7->0.
REQ-024 On the sck rise that wraps the counter to 0, rx_data SHALL take the full byte and valid SHALL be 1 in the following clk cycle.
REQ-025 In SEL, each synchronized sck fall SHALL shift the tx shifter left by one bit.
REQ-026 A sck fall with bit counter=0 (byte boundary) SHALL reload the tx shifter per REQ-022 instead of shifting.
REQ-027 miso SHALL equal tx shifter bit 7; miso_oe SHALL equal selected.
REQ-028 A byte completing while valid=1 and rd=0 SHALL set overrun and overwrite rx_data with the new byte.
REQ-029 rd and byte completion in the same cycle SHALL leave valid=1 with the new byte and overrun unchanged by that byte.
REQ-030 rd with valid=0 SHALL have no effect beyond clearing overrun.
REQ-031 wr while tx_full=1 SHALL overwrite the holding register (last write wins).
REQ-032 wr in the same cycle as a shifter load SHALL load the old holding value into the shifter, store the new value, and keep tx_full=1.
REQ-033 A cs_n rise mid-byte SHALL discard the partial rx byte, leave valid/rx_data unchanged, and return to IDLE.
REQ-034 A holding byte already loaded into the shifter SHALL be lost if cs_n rises mid-byte.
REQ-035 sck edges while IDLE SHALL be ignored.

Reset
REQ-036 On resetq low, all outputs SHALL go to 0 immediately: miso=0, miso_oe=0, rx_data=0, valid=0, tx_full=0, overrun=0, selected=0.
REQ-037 On resetq low, the state SHALL go to IDLE and the counter, shifters and synchronizers SHALL clear; synchronizer reset value for cs_n SHALL be 1.
REQ-038 Reset asserted mid-transfer SHALL abort the transfer; after release the block SHALL wait for a fresh cs_n fall.

Structure
REQ-039 No shared package SHALL be used; state encodings SHALL be localparams in the module.
REQ-040 One sub-module SHALL be used: spi_sync, a parameterized N-stage synchronizer with reset value, instantiated three times.

Verification
REQ-041 Host sends 8'hA5 at clk/8 with wr never pulsed -> valid=1 with rx_data=8'hA5, miso bits read 1,1,1,1,1,1,1,1, overrun=0.
REQ-042 wr tx_data=8'h3C before cs_n fall, host sends 8'h00 -> host reads 8'h3C, and tx_full goes 0 after the cs_n fall.
REQ-043 Host sends 8'h11 then 8'h22 with no rd -> rx_data=8'h22, valid=1, overrun=1; a rd pulse then gives valid=0, overrun=0.
REQ-044 rd pulsed on the completion cycle of byte 8'h55 -> valid=1, rx_data=8'h55, overrun=0.
REQ-045 cs_n rises after 5 sck edges, then a full byte 8'hC3 is sent -> only 8'hC3 is received and the partial byte is never reported.
REQ-046 resetq pulsed low after 4 bits -> all outputs 0 at once; next full transaction 8'h81 is received correctly.
